// File: rtl/servant_sim_monitor_if.sv
// Signal bundle between the servant SoC bus taps and the sim monitor.
// The master side drives the Wishbone/GPIO taps and pops the trace; the slave is the monitor.
interface servant_sim_monitor_if #(
  parameter int GPIO_W = 1
);
  logic [31:0]       i_wb_adr;
  logic [31:0]       i_wb_dat;
  logic              i_wb_we;
  logic              i_wb_stb;
  logic              i_wb_ack;
  logic [GPIO_W-1:0] i_q;
  logic              i_trace_rd;
  logic [31:0]       o_trace_adr;
  logic              o_trace_vld;
  logic              o_trace_ovf;
  logic [31:0]       o_rd_cnt;
  logic [15:0]       o_tgl_cnt;
  logic              o_done;
  logic              o_pass;
  logic              o_timeout;

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_we, i_wb_stb, i_wb_ack, i_q, i_trace_rd,
    input  o_trace_adr, o_trace_vld, o_trace_ovf, o_rd_cnt, o_tgl_cnt,
           o_done, o_pass, o_timeout
  );
  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_stb, i_wb_ack, i_q, i_trace_rd,
    output o_trace_adr, o_trace_vld, o_trace_ovf, o_rd_cnt, o_tgl_cnt,
           o_done, o_pass, o_timeout
  );
endinterface

// File: rtl/servant_sim_monitor.sv
// Sim-side monitor for the servant SoC: read-address trace FIFO, read/GPIO-toggle counters,
// halt/pass capture and a reset-relative watchdog. Everything freezes once the test ends.
module servant_sim_monitor #(
  parameter int          TRACE_DEPTH = 16,
  parameter int          WRAP        = 0,
  parameter logic [31:0] HALT_ADR    = 32'h9000_0000,
  parameter int unsigned TIMEOUT     = 0,
  parameter int          GPIO_W      = 1
) (
  input logic                  wb_clk,
  input logic                  wb_rst,
  servant_sim_monitor_if.slave bus
);
  localparam int AW = $clog2(TRACE_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(TRACE_DEPTH);

  logic [31:0]       mem [TRACE_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       occ;
  logic              ovf, done, pass, tmo;
  logic [31:0]       rd_cnt, wd_cnt;
  logic [15:0]       tgl_cnt;
  logic [GPIO_W-1:0] q_r;
  logic              frozen, bus_hit, rd_evt, halt_evt, pop, full, wr_en, rd_adv, wd_hit;

  assign frozen   = done | tmo;
  assign bus_hit  = bus.i_wb_stb & bus.i_wb_ack & ~frozen;
  assign rd_evt   = bus_hit & ~bus.i_wb_we;
  assign halt_evt = bus_hit & bus.i_wb_we & (bus.i_wb_adr == HALT_ADR);
  assign full     = (occ == DEPTH_L);
  assign pop      = bus.i_trace_rd & (occ != '0);
  // A full FIFO still accepts a push if the head leaves this cycle or in overwrite mode.
  assign wr_en    = rd_evt & (~full | pop | (WRAP != 0));
  assign rd_adv   = pop | (rd_evt & full & (WRAP != 0));
  assign wd_hit   = (TIMEOUT != 0) && (wd_cnt == 32'(TIMEOUT - 1));

  always_ff @(posedge wb_clk) begin
    if (wr_en) mem[wr_ptr] <= bus.i_wb_adr;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      ovf     <= 1'b0;
      rd_cnt  <= '0;
      tgl_cnt <= '0;
      q_r     <= '0;
      wd_cnt  <= '0;
      done    <= 1'b0;
      pass    <= 1'b0;
      tmo     <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
      if (rd_evt & ~pop & ~full)    occ <= occ + 1'b1;
      else if (pop & ~rd_evt)       occ <= occ - 1'b1;
      if (rd_evt & full & ~pop)     ovf <= 1'b1;
      if (rd_evt && rd_cnt != '1)   rd_cnt <= rd_cnt + 1'b1;
      q_r <= bus.i_q;
      if (~frozen && bus.i_q != q_r && tgl_cnt != '1) tgl_cnt <= tgl_cnt + 1'b1;
      if (~frozen) wd_cnt <= wd_cnt + 1'b1;
      // Halt in the expiry cycle takes priority over the watchdog.
      if (halt_evt) begin
        done <= 1'b1;
        pass <= (bus.i_wb_dat == '0);
      end else if (wd_hit & ~frozen) begin
        tmo <= 1'b1;
      end
    end
  end

  assign bus.o_trace_adr = (occ == '0) ? '0 : mem[rd_ptr];
  assign bus.o_trace_vld = (occ != '0);
  assign bus.o_trace_ovf = ovf;
  assign bus.o_rd_cnt    = rd_cnt;
  assign bus.o_tgl_cnt   = tgl_cnt;
  assign bus.o_done      = done;
  assign bus.o_pass      = pass;
  assign bus.o_timeout   = tmo;
endmodule

// File: tb/tb_servant_sim_monitor.sv
// Randomised + directed bench for servant_sim_monitor: two instances (drop / overwrite mode,
// watchdog off / on) fed the same stimulus and compared against a queue-based reference model.
module tb_servant_sim_monitor;
  localparam int          D   = 4;
  localparam int          GW  = 2;
  localparam int          TMO = 100;
  localparam logic [31:0] HA  = 32'h9000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]   adr = '0, dat = '0;
  logic          we = 1'b0, stb = 1'b0, ack = 1'b0, trd = 1'b0;
  logic [GW-1:0] q = '0;

  servant_sim_monitor_if #(.GPIO_W(GW)) b0 ();
  servant_sim_monitor_if #(.GPIO_W(GW)) b1 ();

  assign b0.i_wb_adr = adr;  assign b1.i_wb_adr = adr;
  assign b0.i_wb_dat = dat;  assign b1.i_wb_dat = dat;
  assign b0.i_wb_we  = we;   assign b1.i_wb_we  = we;
  assign b0.i_wb_stb = stb;  assign b1.i_wb_stb = stb;
  assign b0.i_wb_ack = ack;  assign b1.i_wb_ack = ack;
  assign b0.i_q      = q;    assign b1.i_q      = q;
  assign b0.i_trace_rd = trd; assign b1.i_trace_rd = trd;

  servant_sim_monitor #(.TRACE_DEPTH(D), .WRAP(0), .HALT_ADR(HA), .TIMEOUT(0), .GPIO_W(GW))
    dut0 (.wb_clk(clk), .wb_rst(rst), .bus(b0.slave));
  servant_sim_monitor #(.TRACE_DEPTH(D), .WRAP(1), .HALT_ADR(HA), .TIMEOUT(TMO), .GPIO_W(GW))
    dut1 (.wb_clk(clk), .wb_rst(rst), .bus(b1.slave));

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 = drop mode / no watchdog, index 1 = overwrite / TIMEOUT=100.
  logic [31:0]   mq [2][$];
  logic          m_ovf [2], m_done [2], m_pass [2], m_to [2];
  logic [31:0]   m_rd [2];
  logic [15:0]   m_tgl [2];
  logic [GW-1:0] m_qp [2];
  int            m_cyc [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_ovf[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_to[i] = 0;
      m_rd[i] = 0; m_tgl[i] = 0; m_qp[i] = 0; m_cyc[i] = 0;
    end
  endtask

  task automatic model_step();
    bit frz, rd, hl, pp;
    int lim;
    for (int i = 0; i < 2; i++) begin
      lim = (i == 1) ? TMO : 0;
      frz = m_done[i] | m_to[i];
      rd  = stb && ack && !we && !frz;
      hl  = stb && ack && we && (adr == HA) && !frz;
      pp  = trd && (mq[i].size() > 0);
      if (pp) void'(mq[i].pop_front());
      if (rd) begin
        if (mq[i].size() < D) mq[i].push_back(adr);
        else begin
          m_ovf[i] = 1;
          if (i == 1) begin
            void'(mq[i].pop_front());
            mq[i].push_back(adr);
          end
        end
        if (m_rd[i] != 32'hFFFF_FFFF) m_rd[i]++;
      end
      if (!frz && q != m_qp[i] && m_tgl[i] != 16'hFFFF) m_tgl[i]++;
      m_qp[i] = q;
      if (hl) begin
        m_done[i] = 1;
        m_pass[i] = (dat == 0);
      end else if (!frz && lim != 0 && m_cyc[i] + 1 == lim) begin
        m_to[i] = 1;
      end
      if (!frz) m_cyc[i]++;
    end
  endtask

  task automatic cmp_dut(input int i, input logic [31:0] tadr, input logic vld, input logic ovf,
                         input logic [31:0] rdc, input logic [15:0] tgl,
                         input logic dn, input logic ps, input logic to);
    string p;
    p = (i == 0) ? "d0" : "d1";
    chk({p, "_vld"},  {31'd0, vld}, {31'd0, mq[i].size() > 0});
    chk({p, "_adr"},  tadr, (mq[i].size() > 0) ? mq[i][0] : 32'd0);
    chk({p, "_ovf"},  {31'd0, ovf}, {31'd0, m_ovf[i]});
    chk({p, "_rd"},   rdc, m_rd[i]);
    chk({p, "_tgl"},  {16'd0, tgl}, {16'd0, m_tgl[i]});
    chk({p, "_done"}, {31'd0, dn}, {31'd0, m_done[i]});
    chk({p, "_pass"}, {31'd0, ps}, {31'd0, m_pass[i]});
    chk({p, "_to"},   {31'd0, to}, {31'd0, m_to[i]});
  endtask

  task automatic cmp_all();
    cmp_dut(0, b0.o_trace_adr, b0.o_trace_vld, b0.o_trace_ovf, b0.o_rd_cnt, b0.o_tgl_cnt,
            b0.o_done, b0.o_pass, b0.o_timeout);
    cmp_dut(1, b1.o_trace_adr, b1.o_trace_vld, b1.o_trace_ovf, b1.o_rd_cnt, b1.o_tgl_cnt,
            b1.o_done, b1.o_pass, b1.o_timeout);
  endtask

  // One bus cycle: drive, clock, advance model, check all outputs.
  task automatic cyc(input bit s, input bit a, input bit w, input logic [31:0] ad,
                     input logic [31:0] dt, input bit tr, input logic [GW-1:0] qq);
    stb = s; ack = a; we = w; adr = ad; dat = dt; trd = tr; q = qq;
    @(posedge clk);
    model_step();
    #1;
    cmp_all();
  endtask

  task automatic rd_bus(input logic [31:0] ad, input bit tr);
    cyc(1, 1, 0, ad, 0, tr, q);
  endtask

  task automatic idle(input bit tr);
    cyc(0, 0, 0, 0, 0, tr, q);
  endtask

  task automatic do_reset();
    stb = 0; ack = 0; we = 0; adr = 0; dat = 0; trd = 0; q = 0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_vld", {31'd0, b0.o_trace_vld | b1.o_trace_vld}, 32'd0);
    chk("rst_rd",  b0.o_rd_cnt | b1.o_rd_cnt, 32'd0);
    chk("rst_ovf", {31'd0, b0.o_trace_ovf | b1.o_trace_ovf}, 32'd0);
    cmp_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [31:0] exp0 [4], exp1 [4];
  int n;

  initial begin
    do_reset();

    // GPIO toggle counting: 00 -> 01 -> 11 -> 11
    cyc(0, 0, 0, 0, 0, 0, 2'b00);
    cyc(0, 0, 0, 0, 0, 0, 2'b01);
    cyc(0, 0, 0, 0, 0, 0, 2'b11);
    cyc(0, 0, 0, 0, 0, 0, 2'b11);
    chk("t7_tgl", {16'd0, b0.o_tgl_cnt}, 32'd2);

    // In-order trace and pop
    rd_bus(32'h0, 0); rd_bus(32'h4, 0); rd_bus(32'h8, 0);
    chk("t2_head0", b0.o_trace_adr, 32'h0);
    idle(1); chk("t2_head1", b0.o_trace_adr, 32'h4);
    idle(1); chk("t2_head2", b0.o_trace_adr, 32'h8);
    idle(1); chk("t2_vld", {31'd0, b0.o_trace_vld}, 32'd0);
    chk("t2_rdcnt", b0.o_rd_cnt, 32'd3);

    // Reset mid-stream with entries queued
    for (int i = 0; i < 5; i++) rd_bus(32'h40 + 32'(i * 4), 0);
    do_reset();

    // Overflow in drop vs overwrite mode
    for (int i = 0; i < 6; i++) rd_bus(32'h10 + 32'(i * 4), 0);
    chk("t3_ovf0", {31'd0, b0.o_trace_ovf}, 32'd1);
    chk("t3_ovf1", {31'd0, b1.o_trace_ovf}, 32'd1);
    chk("t3_rd", b0.o_rd_cnt, 32'd6);
    exp0 = '{32'h10, 32'h14, 32'h18, 32'h1C};
    exp1 = '{32'h18, 32'h1C, 32'h20, 32'h24};
    for (int i = 0; i < 4; i++) begin
      chk("t3_h0", b0.o_trace_adr, exp0[i]);
      chk("t3_h1", b1.o_trace_adr, exp1[i]);
      idle(1);
    end
    chk("t3_empty", {31'd0, b0.o_trace_vld | b1.o_trace_vld}, 32'd0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 4; i++) rd_bus(32'(i * 4), 0);
    rd_bus(32'h100, 1);
    chk("t4_ovf", {31'd0, b0.o_trace_ovf | b1.o_trace_ovf}, 32'd0);
    chk("t4_head", b0.o_trace_adr, 32'h4);
    n = 0;
    while (b0.o_trace_vld && n < 10) begin idle(1); n++; end
    chk("t4_occ", 32'(n), 32'd4);

    // Halt with pass, then frozen counters
    do_reset();
    rd_bus(32'h20, 0);
    cyc(1, 1, 1, 32'h1234, 32'h5, 0, q);
    chk("t5_nohalt", {31'd0, b0.o_done}, 32'd0);
    cyc(1, 1, 1, HA, 32'h0, 0, q);
    chk("t5_done", {31'd0, b0.o_done}, 32'd1);
    chk("t5_pass", {31'd0, b0.o_pass}, 32'd1);
    rd_bus(32'h24, 0);
    chk("t5_frz", b0.o_rd_cnt, 32'd1);
    do_reset();
    cyc(1, 1, 1, HA, 32'h1, 0, q);
    chk("t5_done2", {31'd0, b0.o_done}, 32'd1);
    chk("t5_fail", {31'd0, b0.o_pass}, 32'd0);

    // Watchdog expiry and halt-wins priority
    do_reset();
    for (int i = 0; i < TMO - 1; i++) idle(0);
    chk("t6_early", {31'd0, b1.o_timeout}, 32'd0);
    idle(0);
    chk("t6_to", {31'd0, b1.o_timeout}, 32'd1);
    do_reset();
    for (int i = 0; i < TMO - 1; i++) idle(0);
    cyc(1, 1, 1, HA, 32'h0, 0, q);
    chk("t6_hdone", {31'd0, b1.o_done}, 32'd1);
    chk("t6_hto", {31'd0, b1.o_timeout}, 32'd0);

    // Randomised traffic
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        logic [31:0] ra;
        bit rw, rs;
        rs = ($urandom_range(0, 3) != 0);
        rw = ($urandom_range(0, 7) == 0);
        ra = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        if (rw && $urandom_range(0, 15) == 0) ra = HA;
        cyc(rs, ($urandom_range(0, 3) != 0), rw, ra,
            ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom, ($urandom_range(0, 2) == 0),
            GW'($urandom_range(0, 3)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
